// File: rtl/space_ctrl_pkg.sv
// Shared types and constants for the main controller's register-bus arbitration.
package space_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    // Wide enough for any practical bus; users slice it down to DATA_WIDTH.
    localparam int unsigned ERR_RDATA_MAX_WIDTH = 256;
    localparam logic [ERR_RDATA_MAX_WIDTH-1:0] ERR_RDATA = '1;

endpackage

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register bus between the Wishbone host (m0)
// and the UART command decoder (m1), with a watchdog that ends stalled accesses.
module reg_bus_arbiter
    import space_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    m0_valid_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb_i,
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_ready_o,
    output logic                    m0_err_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,

    input  logic                    m1_valid_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb_i,
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_ready_o,
    output logic                    m1_err_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,

    output logic                    s_valid_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_wstrb_o,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_wdata_o,
    input  logic                    s_ready_i,
    input  logic [DATA_WIDTH-1:0]   s_rdata_i,

    output logic [1:0]              grant_o
);

    localparam logic [7:0]            TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] ERR_WORD     = ERR_RDATA[DATA_WIDTH-1:0];

    state_t     state, state_next;
    logic       last_grant;
    logic [7:0] wait_count;
    logic       grant_take;
    logic       grant_idx;
    logic       owner_valid;
    logic       timed_out;
    logic       finish;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_next  = state;
        grant_take  = 1'b0;
        grant_idx   = REQ_M0;
        owner_valid = 1'b0;
        timed_out   = 1'b0;
        finish      = 1'b0;
        m0_ready_o  = 1'b0;
        m0_err_o    = 1'b0;
        m0_rdata_o  = '0;
        m1_ready_o  = 1'b0;
        m1_err_o    = 1'b0;
        m1_rdata_o  = '0;

        case (state)
            IDLE: begin
                if (m0_valid_i && m1_valid_i) begin
                    grant_take = 1'b1;
                    grant_idx  = (last_grant == REQ_M1) ? REQ_M0 : REQ_M1;
                end else if (m0_valid_i || m1_valid_i) begin
                    grant_take = 1'b1;
                    grant_idx  = m1_valid_i ? REQ_M1 : REQ_M0;
                end
                if (grant_take) state_next = (grant_idx == REQ_M0) ? GNT0 : GNT1;
            end
            GNT0, GNT1: begin
                // A dropped request aborts silently, even if the slave answers now.
                owner_valid = (state == GNT0) ? m0_valid_i : m1_valid_i;
                timed_out   = !s_ready_i && (wait_count == TIMEOUT_LAST);
                finish      = owner_valid && (s_ready_i || timed_out);
                if (!owner_valid || finish) state_next = IDLE;
                if (finish) begin
                    if (state == GNT0) begin
                        m0_ready_o = 1'b1;
                        m0_err_o   = timed_out;
                        m0_rdata_o = timed_out ? ERR_WORD : s_rdata_i;
                    end else begin
                        m1_ready_o = 1'b1;
                        m1_err_o   = timed_out;
                        m1_rdata_o = timed_out ? ERR_WORD : s_rdata_i;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign grant_o = {state == GNT1, state == GNT0};

    // Slave fields are captured once at grant so requester-side changes cannot leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid_o  <= 1'b0;
            s_we_o     <= 1'b0;
            s_wstrb_o  <= '0;
            s_adr_o    <= '0;
            s_wdata_o  <= '0;
            wait_count <= '0;
            last_grant <= REQ_M1;
        end else if (grant_take) begin
            s_valid_o  <= 1'b1;
            s_we_o     <= (grant_idx == REQ_M0) ? m0_we_i    : m1_we_i;
            s_wstrb_o  <= (grant_idx == REQ_M0) ? m0_wstrb_i : m1_wstrb_i;
            s_adr_o    <= (grant_idx == REQ_M0) ? m0_adr_i   : m1_adr_i;
            s_wdata_o  <= (grant_idx == REQ_M0) ? m0_wdata_i : m1_wdata_i;
            wait_count <= '0;
            last_grant <= grant_idx;
        end else if (state != IDLE) begin
            if (state_next == IDLE)       s_valid_o  <= 1'b0;
            else if (wait_count != 8'hFF) wait_count <= wait_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Self-checking bench for reg_bus_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin/timeout model.
module tb_reg_bus_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_valid = 1'b0, m0_we = 1'b0;
    logic [3:0]    m0_wstrb = '0;
    logic [AW-1:0] m0_adr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_ready, m0_err;
    logic [DW-1:0] m0_rdata;
    logic          m1_valid = 1'b0, m1_we = 1'b0;
    logic [3:0]    m1_wstrb = '0;
    logic [AW-1:0] m1_adr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_ready, m1_err;
    logic [DW-1:0] m1_rdata;
    logic          s_valid, s_we;
    logic [3:0]    s_wstrb;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_wdata;
    logic          s_ready = 1'b0;
    logic [DW-1:0] s_rdata = '0;
    logic [1:0]    grant;

    int checks = 0;
    int errors = 0;
    int model_prev = 1;

    logic          cap_we;
    logic [3:0]    cap_wstrb;
    logic [AW-1:0] cap_adr;
    logic [DW-1:0] cap_wdata;
    bit            cap_stable;
    bit            loser_quiet;

    reg_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .m0_valid_i(m0_valid), .m0_we_i(m0_we), .m0_wstrb_i(m0_wstrb), .m0_adr_i(m0_adr),
        .m0_wdata_i(m0_wdata), .m0_ready_o(m0_ready), .m0_err_o(m0_err), .m0_rdata_o(m0_rdata),
        .m1_valid_i(m1_valid), .m1_we_i(m1_we), .m1_wstrb_i(m1_wstrb), .m1_adr_i(m1_adr),
        .m1_wdata_i(m1_wdata), .m1_ready_o(m1_ready), .m1_err_o(m1_err), .m1_rdata_o(m1_rdata),
        .s_valid_o(s_valid), .s_we_o(s_we), .s_wstrb_o(s_wstrb), .s_adr_o(s_adr),
        .s_wdata_o(s_wdata), .s_ready_i(s_ready), .s_rdata_i(s_rdata),
        .grant_o(grant)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Runs one transaction from IDLE; slave raises ready in grant cycle ready_at (0 = never).
    // Returns at posedge+1 of the cycle after completion with all requests dropped.
    task automatic drive_txn(input logic v0, input logic v1, input int ready_at,
                             input logic [DW-1:0] srd, output int winner, output int done_cyc,
                             output logic done_err, output logic [DW-1:0] done_rdata);
        int cyc = 0;
        bit finished = 0;
        winner = -1; done_cyc = 0; done_err = 1'b0; done_rdata = '0;
        cap_stable = 1; loser_quiet = 1;
        m0_valid = v0; m1_valid = v1;
        for (int t = 0; t < 64 && !finished; t++) begin
            @(posedge clk); #1;
            if (grant != 2'b00) begin
                cyc++;
                if (!s_valid) cap_stable = 0;
                if (cyc == 1) begin
                    winner = (grant == 2'b01) ? 0 : ((grant == 2'b10) ? 1 : 2);
                    cap_we = s_we; cap_wstrb = s_wstrb; cap_adr = s_adr; cap_wdata = s_wdata;
                    m0_we = 1'($urandom); m0_wstrb = 4'($urandom); m0_adr = $urandom; m0_wdata = $urandom;
                    m1_we = 1'($urandom); m1_wstrb = 4'($urandom); m1_adr = $urandom; m1_wdata = $urandom;
                end else if ({s_we, s_wstrb, s_adr, s_wdata} !== {cap_we, cap_wstrb, cap_adr, cap_wdata}) begin
                    cap_stable = 0;
                end
                s_ready = (cyc == ready_at);
                s_rdata = s_ready ? srd : $urandom;
                @(negedge clk);
                if (winner == 0 && ({m1_ready, m1_err, m1_rdata} !== '0)) loser_quiet = 0;
                if (winner == 1 && ({m0_ready, m0_err, m0_rdata} !== '0)) loser_quiet = 0;
                if ((winner == 0 && m0_ready === 1'b1) || (winner == 1 && m1_ready === 1'b1)) begin
                    finished   = 1;
                    done_cyc   = cyc;
                    done_err   = (winner == 0) ? m0_err : m1_err;
                    done_rdata = (winner == 0) ? m0_rdata : m1_rdata;
                end
            end
        end
        @(posedge clk); #1;
        s_ready = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0;
    endtask

    task automatic apply_reset();
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        model_prev = 1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({s_valid, s_we, s_wstrb, grant} !== 8'h00) begin
            errors++; $display("FAIL reset_ctrl got %h expected 00", {s_valid, s_we, s_wstrb, grant});
        end
        checks++;
        if ({s_adr, s_wdata} !== 64'h0) begin
            errors++; $display("FAIL reset_s_fields got %h expected 0", {s_adr, s_wdata});
        end
        checks++;
        if ({m0_ready, m0_err, m0_rdata, m1_ready, m1_err, m1_rdata} !== '0) begin
            errors++; $display("FAIL reset_m_outputs got %h %h expected 0", m0_rdata, m1_rdata);
        end
        m0_valid = 1'b1; m1_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (grant !== 2'b00) begin
            errors++; $display("FAIL reset_hold_grant got %b expected 00", grant);
        end
        m0_valid = 1'b0; m1_valid = 1'b0; rst = 1'b0;
        model_prev = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_write();
        int w, c; logic e; logic [DW-1:0] r;
        s_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({m0_ready, m1_ready} !== 2'b00) begin
            errors++; $display("FAIL idle_ready_ignored got %b expected 00", {m0_ready, m1_ready});
        end
        @(posedge clk); #1;
        s_ready = 1'b0;
        checks++;
        if (grant !== 2'b00) begin
            errors++; $display("FAIL idle_ready_grant got %b expected 00", grant);
        end
        m0_we = 1'b1; m0_wstrb = 4'hF; m0_adr = 32'h3000_0004; m0_wdata = 32'hA5A5_A5A5;
        drive_txn(1'b1, 1'b0, 4, 32'h0, w, c, e, r);
        checks++;
        if (w != 0 || c != 4 || e !== 1'b0) begin
            errors++; $display("FAIL write_done got w=%0d cyc=%0d err=%b expected w=0 cyc=4 err=0", w, c, e);
        end
        checks++;
        if ({cap_we, cap_wstrb, cap_adr, cap_wdata} !== {1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_A5A5} || !cap_stable) begin
            errors++; $display("FAIL write_s_fields got %b %h %h %h stable=%0d expected 1 f 30000004 a5a5a5a5 stable=1",
                               cap_we, cap_wstrb, cap_adr, cap_wdata, cap_stable);
        end
        checks++;
        if (grant !== 2'b00 || m0_ready !== 1'b0 || s_valid !== 1'b0) begin
            errors++; $display("FAIL write_idle_after got grant=%b ready=%b s_valid=%b expected 00 0 0", grant, m0_ready, s_valid);
        end
        model_prev = 0;
    endtask

    task automatic test_contention();
        int w, c, exp_w; logic e; logic [DW-1:0] r, srd;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            srd = $urandom;
            exp_w = 1 - model_prev;
            drive_txn(1'b1, 1'b1, 2, srd, w, c, e, r);
            checks++;
            if (w != exp_w || c != 2 || e !== 1'b0 || r !== srd) begin
                errors++; $display("FAIL contention_round%0d got w=%0d cyc=%0d err=%b rdata=%h expected w=%0d cyc=2 err=0 rdata=%h",
                                   k, w, c, e, r, exp_w, srd);
            end
            checks++;
            if (grant !== 2'b00 || !loser_quiet) begin
                errors++; $display("FAIL contention_idle%0d got grant=%b quiet=%0d expected 00 1", k, grant, loser_quiet);
            end
            model_prev = exp_w;
        end
    endtask

    task automatic test_timeout();
        int w, c; logic e; logic [DW-1:0] r;
        m1_we = 1'b0; m1_adr = 32'h3000_0010; m1_wstrb = 4'h0;
        drive_txn(1'b0, 1'b1, 0, 32'h0, w, c, e, r);
        checks++;
        if (w != 1 || c != TMO || e !== 1'b1 || r !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL timeout got w=%0d cyc=%0d err=%b rdata=%h expected w=1 cyc=%0d err=1 rdata=ffffffff",
                               w, c, e, r, TMO);
        end
        checks++;
        if (grant !== 2'b00 || s_valid !== 1'b0 || m1_ready !== 1'b0) begin
            errors++; $display("FAIL timeout_idle got grant=%b s_valid=%b ready=%b expected 00 0 0", grant, s_valid, m1_ready);
        end
        model_prev = 1;
    endtask

    task automatic test_ready_at_timeout();
        int w, c; logic e; logic [DW-1:0] r;
        m0_we = 1'b0;
        drive_txn(1'b1, 1'b0, TMO, 32'h1234_5678, w, c, e, r);
        checks++;
        if (w != 0 || c != TMO || e !== 1'b0 || r !== 32'h1234_5678) begin
            errors++; $display("FAIL ready_at_timeout got w=%0d cyc=%0d err=%b rdata=%h expected w=0 cyc=%0d err=0 rdata=12345678",
                               w, c, e, r, TMO);
        end
        model_prev = 0;
    endtask

    task automatic test_abort();
        m0_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (grant !== 2'b01) begin
            errors++; $display("FAIL abort_grant0 got %b expected 01", grant);
        end
        m1_valid = 1'b1;
        @(posedge clk); #1;
        m0_valid = 1'b0; s_ready = 1'b1; s_rdata = $urandom;
        @(negedge clk);
        checks++;
        if ({m0_ready, m0_err, m1_ready, m1_err} !== 4'b0000) begin
            errors++; $display("FAIL abort_no_pulse got %b expected 0000", {m0_ready, m0_err, m1_ready, m1_err});
        end
        @(posedge clk); #1;
        s_ready = 1'b0;
        checks++;
        if (s_valid !== 1'b0 || grant !== 2'b00) begin
            errors++; $display("FAIL abort_idle got s_valid=%b grant=%b expected 0 00", s_valid, grant);
        end
        @(posedge clk); #1;
        checks++;
        if (grant !== 2'b10 || s_valid !== 1'b1) begin
            errors++; $display("FAIL abort_pending_m1 got grant=%b s_valid=%b expected 10 1", grant, s_valid);
        end
        s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        checks++;
        if (m1_ready !== 1'b1 || m1_rdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL abort_m1_done got ready=%b rdata=%h expected 1 cafef00d", m1_ready, m1_rdata);
        end
        @(posedge clk); #1;
        s_ready = 1'b0; m1_valid = 1'b0;
        model_prev = 1;
    endtask

    task automatic test_async_reset();
        int w, c; logic e; logic [DW-1:0] r;
        m0_valid = 1'b1;
        @(posedge clk); #1;
        s_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (m0_ready !== 1'b1 || grant !== 2'b01) begin
            errors++; $display("FAIL arst_pre got ready=%b grant=%b expected 1 01", m0_ready, grant);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({s_valid, grant, m0_ready, m0_err, m1_ready, m1_err} !== 7'b0 || s_adr !== '0) begin
            errors++; $display("FAIL arst_immediate got %b adr=%h expected 0000000 adr=0",
                               {s_valid, grant, m0_ready, m0_err, m1_ready, m1_err}, s_adr);
        end
        s_ready = 1'b0; m0_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_prev = 1;
        drive_txn(1'b1, 1'b1, 2, 32'h0, w, c, e, r);
        checks++;
        if (w != 0) begin
            errors++; $display("FAIL arst_first_winner got %0d expected 0", w);
        end
        model_prev = 0;
    endtask

    task automatic test_random();
        int w, c, exp_w, exp_c, ra; logic e, exp_e; logic [DW-1:0] r, srd, exp_r;
        logic [1:0] v;
        logic req_we[2]; logic [3:0] req_wstrb[2]; logic [AW-1:0] req_adr[2]; logic [DW-1:0] req_wdata[2];
        for (int i = 0; i < 24; i++) begin
            v  = 2'($urandom_range(1, 3));
            ra = $urandom_range(2, 20);
            srd = $urandom;
            for (int q = 0; q < 2; q++) begin
                req_we[q] = 1'($urandom); req_wstrb[q] = 4'($urandom);
                req_adr[q] = $urandom; req_wdata[q] = $urandom;
            end
            m0_we = req_we[0]; m0_wstrb = req_wstrb[0]; m0_adr = req_adr[0]; m0_wdata = req_wdata[0];
            m1_we = req_we[1]; m1_wstrb = req_wstrb[1]; m1_adr = req_adr[1]; m1_wdata = req_wdata[1];
            exp_w = (v == 2'b11) ? (1 - model_prev) : (v[0] ? 0 : 1);
            exp_e = (ra > TMO);
            exp_c = exp_e ? TMO : ra;
            exp_r = exp_e ? 32'hFFFF_FFFF : srd;
            drive_txn(v[0], v[1], ra, srd, w, c, e, r);
            checks++;
            if (w != exp_w || c != exp_c || e !== exp_e || r !== exp_r) begin
                errors++; $display("FAIL rand%0d_done got w=%0d cyc=%0d err=%b rdata=%h expected w=%0d cyc=%0d err=%b rdata=%h",
                                   i, w, c, e, r, exp_w, exp_c, exp_e, exp_r);
            end
            if (exp_w == w) begin
                checks++;
                if ({cap_we, cap_wstrb, cap_adr, cap_wdata} !== {req_we[exp_w], req_wstrb[exp_w], req_adr[exp_w], req_wdata[exp_w]}
                    || !cap_stable) begin
                    errors++; $display("FAIL rand%0d_fields got %b %h %h %h stable=%0d expected %b %h %h %h stable=1", i,
                                       cap_we, cap_wstrb, cap_adr, cap_wdata, cap_stable,
                                       req_we[exp_w], req_wstrb[exp_w], req_adr[exp_w], req_wdata[exp_w]);
                end
            end
            checks++;
            if (!loser_quiet || grant !== 2'b00) begin
                errors++; $display("FAIL rand%0d_quiet got quiet=%0d grant=%b expected 1 00", i, loser_quiet, grant);
            end
            model_prev = exp_w;
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_timeout();
        test_ready_at_timeout();
        test_abort();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
